// File: rtl/nlfsr_ctrl_pkg.sv
// Shared constants and FSM encoding for the masked TinyJAMBU state-update controller.
package nlfsr_ctrl_pkg;

    localparam int unsigned SHARES  = 4;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned FB_W    = 32;
    localparam int unsigned STEP_W  = 6;

    localparam int unsigned TAP_47 = 47;
    localparam int unsigned TAP_70 = 70;
    localparam int unsigned TAP_85 = 85;
    localparam int unsigned TAP_91 = 91;

    // The core needs s[70 +: 32] and s[85 +: 32], i.e. the window s[116:70].
    localparam int unsigned CORE_X_W = TAP_85 + FB_W - TAP_70;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        UPDATE,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/nlfsr_feedback_share.sv
// One share of the NLFSR step: linear taps + nand share + key word, then a 32-bit shift.
module nlfsr_feedback_share
    import nlfsr_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0] s,
    input  logic [FB_W-1:0]    core_y,
    input  logic [FB_W-1:0]    key_word,
    output logic [STATE_W-1:0] s_next_c
);

    logic [FB_W-1:0] fb_c;

    always_comb begin
        fb_c     = s[FB_W-1:0] ^ s[TAP_47 +: FB_W] ^ s[TAP_91 +: FB_W] ^ core_y ^ key_word;
        s_next_c = {fb_c, s[STATE_W-1:FB_W]};
    end

endmodule

// File: rtl/nlfsr_state_ctrl_d3.sv
// Masked (4-share) TinyJAMBU state-update controller driving a multi-cycle nand core.
// Build option: NLFSR_CTRL_IDLE_ZERO_EN forces core_x to zero while IDLE or DONE.
module nlfsr_state_ctrl_d3
    import nlfsr_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned KEY_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [STATE_W-1:0]  state_in_s0,
    input  logic [STATE_W-1:0]  state_in_s1,
    input  logic [STATE_W-1:0]  state_in_s2,
    input  logic [STATE_W-1:0]  state_in_s3,
    input  logic [STATE_W-1:0]  key_s0,
    input  logic [STATE_W-1:0]  key_s1,
    input  logic [STATE_W-1:0]  key_s2,
    input  logic [STATE_W-1:0]  key_s3,
    input  logic                start,
    input  logic [STEP_W-1:0]   num_steps,
    output logic                busy,
    output logic                done,
    output logic [STATE_W-1:0]  state_out_s0,
    output logic [STATE_W-1:0]  state_out_s1,
    output logic [STATE_W-1:0]  state_out_s2,
    output logic [STATE_W-1:0]  state_out_s3,
    output logic [CORE_X_W-1:0] core_x_s0,
    output logic [CORE_X_W-1:0] core_x_s1,
    output logic [CORE_X_W-1:0] core_x_s2,
    output logic [CORE_X_W-1:0] core_x_s3,
    input  logic [FB_W-1:0]     core_y_s0,
    input  logic [FB_W-1:0]     core_y_s1,
    input  logic [FB_W-1:0]     core_y_s2,
    input  logic [FB_W-1:0]     core_y_s3,
    output logic                fresh_en
);

    localparam int unsigned WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned KW_W   = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int unsigned FB_SH  = $clog2(FB_W);

    ctrl_state_e         state_q, state_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [STEP_W-1:0]   num_steps_q, num_steps_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fresh_en_q, fresh_en_d;

    logic [STATE_W-1:0]  s_q [SHARES];
    logic [STATE_W-1:0]  s_d [SHARES];
    logic [STATE_W-1:0]  s_next_c [SHARES];
    logic [STATE_W-1:0]  state_in_a [SHARES];
    logic [STATE_W-1:0]  key_a [SHARES];
    logic [FB_W-1:0]     core_y_a [SHARES];
    logic [FB_W-1:0]     key_word_c [SHARES];
    logic [CORE_X_W-1:0] core_x_c [SHARES];
    logic [KW_W-1:0]     key_idx_c;

    assign state_in_a = '{state_in_s0, state_in_s1, state_in_s2, state_in_s3};
    assign key_a      = '{key_s0, key_s1, key_s2, key_s3};
    assign core_y_a   = '{core_y_s0, core_y_s1, core_y_s2, core_y_s3};

    // Key word for step j is word (j mod KEY_WORDS); the key port holds at most 4 words.
    assign key_idx_c = KW_W'(32'(step_cnt_q) % KEY_WORDS);

    for (genvar i = 0; i < SHARES; i++) begin : g_share
        assign key_word_c[i] = key_a[i][{key_idx_c, FB_SH'(0)} +: FB_W];

        nlfsr_feedback_share u_fb (
            .s        (s_q[i]),
            .core_y   (core_y_a[i]),
            .key_word (key_word_c[i]),
            .s_next_c (s_next_c[i])
        );

`ifdef NLFSR_CTRL_IDLE_ZERO_EN
        assign core_x_c[i] = (state_q == IDLE || state_q == DONE) ? '0 : s_q[i][TAP_70 +: CORE_X_W];
`else
        assign core_x_c[i] = s_q[i][TAP_70 +: CORE_X_W];
`endif
    end

    // Next-state, counters and state-share update.
    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        num_steps_d = num_steps_q;
        wait_cnt_d  = wait_cnt_q;
        for (int unsigned i = 0; i < SHARES; i++) begin
            s_d[i] = s_q[i];
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    for (int unsigned i = 0; i < SHARES; i++) begin
                        s_d[i] = state_in_a[i];
                    end
                end else if (start) begin
                    num_steps_d = num_steps;
                    step_cnt_d  = '0;
                    wait_cnt_d  = '0;
                    state_d     = (num_steps == '0) ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                if (wait_cnt_q == WAIT_W'(LATENCY - 1)) begin
                    state_d = UPDATE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            UPDATE: begin
                for (int unsigned i = 0; i < SHARES; i++) begin
                    s_d[i] = s_next_c[i];
                end
                if (step_cnt_q == num_steps_q - STEP_W'(1)) begin
                    state_d = DONE;
                end else begin
                    step_cnt_d = step_cnt_q + STEP_W'(1);
                    wait_cnt_d = '0;
                    state_d    = COMPUTE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered, so derive them from the state being entered.
        busy_d     = (state_d == COMPUTE) || (state_d == UPDATE);
        done_d     = (state_d == DONE);
        fresh_en_d = (state_d == COMPUTE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            step_cnt_q  <= '0;
            num_steps_q <= '0;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fresh_en_q  <= 1'b0;
            for (int unsigned i = 0; i < SHARES; i++) begin
                s_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            num_steps_q <= num_steps_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fresh_en_q  <= fresh_en_d;
            for (int unsigned i = 0; i < SHARES; i++) begin
                s_q[i] <= s_d[i];
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign fresh_en     = fresh_en_q;
    assign state_out_s0 = s_q[0];
    assign state_out_s1 = s_q[1];
    assign state_out_s2 = s_q[2];
    assign state_out_s3 = s_q[3];
    assign core_x_s0    = core_x_c[0];
    assign core_x_s1    = core_x_c[1];
    assign core_x_s2    = core_x_c[2];
    assign core_x_s3    = core_x_c[3];

endmodule

// File: tb/tb_nlfsr_state_ctrl_d3.sv
// Directed self-checking bench for nlfsr_state_ctrl_d3 with a 2-cycle masked nand core model.
// Honours NLFSR_CTRL_IDLE_ZERO_EN when the build defines it.
module tb_nlfsr_state_ctrl_d3;

    logic         clk;
    logic         rst;
    logic         load;
    logic         start;
    logic [5:0]   num_steps;
    logic [127:0] st_in [4];
    logic [127:0] key [4];
    logic [127:0] st_out [4];
    logic [46:0]  cx [4];
    logic [31:0]  y1 [4];
    logic [31:0]  y2 [4];
    logic         busy;
    logic         done;
    logic         fresh_en;

    int n_checks = 0;
    int n_fail   = 0;

    nlfsr_state_ctrl_d3 #(.LATENCY(2), .KEY_WORDS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .state_in_s0  (st_in[0]),
        .state_in_s1  (st_in[1]),
        .state_in_s2  (st_in[2]),
        .state_in_s3  (st_in[3]),
        .key_s0       (key[0]),
        .key_s1       (key[1]),
        .key_s2       (key[2]),
        .key_s3       (key[3]),
        .start        (start),
        .num_steps    (num_steps),
        .busy         (busy),
        .done         (done),
        .state_out_s0 (st_out[0]),
        .state_out_s1 (st_out[1]),
        .state_out_s2 (st_out[2]),
        .state_out_s3 (st_out[3]),
        .core_x_s0    (cx[0]),
        .core_x_s1    (cx[1]),
        .core_x_s2    (cx[2]),
        .core_x_s3    (cx[3]),
        .core_y_s0    (y2[0]),
        .core_y_s1    (y2[1]),
        .core_y_s2    (y2[2]),
        .core_y_s3    (y2[3]),
        .fresh_en     (fresh_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Masked nand core: two pipeline stages, output remasked with fresh randomness every cycle.
    always @(posedge clk) begin
        logic [46:0] x;
        logic [31:0] nd, r1, r2, r3;
        x  = cx[0] ^ cx[1] ^ cx[2] ^ cx[3];
        nd = ~(x[31:0] & x[46:15]);
        r1 = $urandom;
        r2 = $urandom;
        r3 = $urandom;
        y1[0] <= nd ^ r1 ^ r2 ^ r3;
        y1[1] <= r1;
        y1[2] <= r2;
        y1[3] <= r3;
        for (int i = 0; i < 4; i++) y2[i] <= y1[i];
    end

    function automatic logic [127:0] ref_perm(input logic [127:0] s0, input logic [127:0] k, input int n);
        logic [127:0] s;
        logic [31:0]  f;
        logic [31:0]  kw;
        s = s0;
        for (int j = 0; j < n; j++) begin
            kw = k[32*(j % 4) +: 32];
            f  = s[31:0] ^ s[78:47] ^ ~(s[101:70] & s[116:85]) ^ s[122:91] ^ kw;
            s  = {f, s[127:32]};
        end
        return s;
    endfunction

    function automatic logic [127:0] rec();
        return st_out[0] ^ st_out[1] ^ st_out[2] ^ st_out[3];
    endfunction

    task automatic set_key(input logic [127:0] k);
        logic [127:0] r1, r2, r3;
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        r3 = {$urandom, $urandom, $urandom, $urandom};
        key[0] = k ^ r1 ^ r2 ^ r3;
        key[1] = r1;
        key[2] = r2;
        key[3] = r3;
    endtask

    task automatic share_state(input logic [127:0] p);
        logic [127:0] r1, r2, r3;
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        r3 = {$urandom, $urandom, $urandom, $urandom};
        st_in[0] = p ^ r1 ^ r2 ^ r3;
        st_in[1] = r1;
        st_in[2] = r2;
        st_in[3] = r3;
    endtask

    task automatic load_state(input logic [127:0] p);
        share_state(p);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Starts a run and observes it until done; lat counts edges from the accepting edge (inclusive).
    task automatic run_perm(input int n, input bit disturb, output int lat, output int busy_n,
                            output int fresh_n, output int cx_chg, output int cx_bad, output logic done_after);
        logic [46:0] prev [4];
        logic        prev_busy, prev_upd, ch;
        lat = 0; busy_n = 0; fresh_n = 0; cx_chg = 0; cx_bad = 0;
        prev_busy = 1'b0; prev_upd = 1'b0;
        for (int i = 0; i < 4; i++) prev[i] = cx[i];
        start = 1'b1;
        num_steps = 6'(n);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            if (busy) busy_n++;
            if (fresh_en) fresh_n++;
            ch = (cx[0] != prev[0]) || (cx[1] != prev[1]) || (cx[2] != prev[2]) || (cx[3] != prev[3]);
            if (prev_busy && busy && ch) begin
                cx_chg++;
                if (!(prev_upd && fresh_en)) cx_bad++;
            end
            for (int i = 0; i < 4; i++) prev[i] = cx[i];
            prev_busy = busy;
            prev_upd  = busy && !fresh_en;
            if (disturb && k == 5) begin
                start = 1'b1;
                load  = 1'b1;
                num_steps = 6'd63;
                for (int i = 0; i < 4; i++) st_in[i] = {$urandom, $urandom, $urandom, $urandom};
            end else if (disturb && k == 6) begin
                start = 1'b0;
                load  = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fresh_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b fresh_en=%b expected 000", busy, done, fresh_en);
        end
        n_checks++;
        if ((st_out[0] | st_out[1] | st_out[2] | st_out[3]) !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", st_out[0] | st_out[1] | st_out[2] | st_out[3]);
        end
        n_checks++;
        if ((cx[0] | cx[1] | cx[2] | cx[3]) !== 47'h0) begin
            n_fail++;
            $display("FAIL reset_core_x: got %h expected 0", cx[0] | cx[1] | cx[2] | cx[3]);
        end
    endtask

    task automatic test_zero_state();
        int lat, bn, fn, cc, cb;
        logic da;
        for (int i = 0; i < 4; i++) begin
            st_in[i] = '0;
            key[i]   = '0;
        end
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        run_perm(1, 1'b0, lat, bn, fn, cc, cb, da);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL zero_latency: got %0d expected 4", lat); end
        n_checks++;
        if (rec() !== 128'hFFFFFFFF_00000000_00000000_00000000) begin
            n_fail++;
            $display("FAIL zero_state: got %h expected ffffffff000000000000000000000000", rec());
        end
        n_checks++;
        if (bn !== 3 || fn !== 2) begin
            n_fail++;
            $display("FAIL zero_counts: busy=%0d fresh=%0d expected 3 and 2", bn, fn);
        end
        n_checks++;
        if (da !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: done after pulse=%b expected 0", da); end
    endtask

    task automatic test_random_runs();
        logic [127:0] p, k, e12, e32;
        int lat, bn, fn, cc, cb;
        logic da;
        p = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        e12 = ref_perm(p, k, 12);
        e32 = ref_perm(e12, k, 32);
        set_key(k);
        load_state(p);
        run_perm(12, 1'b0, lat, bn, fn, cc, cb, da);
        n_checks++;
        if (rec() !== e12) begin n_fail++; $display("FAIL run12_state: got %h expected %h", rec(), e12); end
        n_checks++;
        if (bn !== 36 || fn !== 24) begin
            n_fail++;
            $display("FAIL run12_counts: busy=%0d fresh=%0d expected 36 and 24", bn, fn);
        end
        n_checks++;
        if (lat !== 37) begin n_fail++; $display("FAIL run12_latency: got %0d expected 37", lat); end
        run_perm(32, 1'b0, lat, bn, fn, cc, cb, da);
        n_checks++;
        if (rec() !== e32) begin n_fail++; $display("FAIL run32_state: got %h expected %h", rec(), e32); end
        n_checks++;
        if (bn !== 96 || fn !== 64) begin
            n_fail++;
            $display("FAIL run32_counts: busy=%0d fresh=%0d expected 96 and 64", bn, fn);
        end
        n_checks++;
        if (lat !== 97 || da !== 1'b0) begin
            n_fail++;
            $display("FAIL run32_done: latency=%0d after=%b expected 97 and 0", lat, da);
        end
    endtask

    task automatic test_reshare();
        logic [127:0] p, k, e;
        int lat, bn, fn, cc, cb;
        logic da;
        p = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
        k = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        e = ref_perm(p, k, 8);
        for (int pass = 0; pass < 2; pass++) begin
            set_key(k);
            load_state(p);
            run_perm(8, 1'b0, lat, bn, fn, cc, cb, da);
            n_checks++;
            if (rec() !== e) begin n_fail++; $display("FAIL reshare_state%0d: got %h expected %h", pass, rec(), e); end
            n_checks++;
            if (cc !== 7 || cb !== 0) begin
                n_fail++;
                $display("FAIL reshare_core_x%0d: changes=%0d misplaced=%0d expected 7 and 0", pass, cc, cb);
            end
        end
    endtask

    task automatic test_zero_steps();
        logic [127:0] p;
        int lat, bn, fn, cc, cb;
        logic da;
        p = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        set_key(128'h11111111_22222222_33333333_44444444);
        load_state(p);
        run_perm(0, 1'b0, lat, bn, fn, cc, cb, da);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL zero_steps_latency: got %0d expected 1", lat); end
        n_checks++;
        if (rec() !== p) begin n_fail++; $display("FAIL zero_steps_state: got %h expected %h", rec(), p); end
        n_checks++;
        if (bn !== 0 || fn !== 0 || da !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_steps_ctrl: busy=%0d fresh=%0d after=%b expected 0 0 0", bn, fn, da);
        end
    endtask

    task automatic test_load_start();
        logic [127:0] p, k, e;
        int lat, bn, fn, cc, cb, dn;
        logic da;
        p = 128'h76543210_FEDCBA98_89ABCDEF_01234567;
        k = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        e = ref_perm(p, k, 4);
        set_key(k);
        share_state(p);
        load = 1'b1;
        start = 1'b1;
        num_steps = 6'd5;
        @(negedge clk);
        load = 1'b0;
        start = 1'b0;
        bn = 0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) bn++;
            if (done) dn++;
            @(negedge clk);
        end
        n_checks++;
        if (bn !== 0 || dn !== 0) begin
            n_fail++;
            $display("FAIL load_start_ignored: busy=%0d done=%0d expected 0 0", bn, dn);
        end
        n_checks++;
        if (rec() !== p) begin n_fail++; $display("FAIL load_start_state: got %h expected %h", rec(), p); end
        run_perm(4, 1'b1, lat, bn, fn, cc, cb, da);
        n_checks++;
        if (rec() !== e) begin n_fail++; $display("FAIL busy_disturb_state: got %h expected %h", rec(), e); end
        n_checks++;
        if (bn !== 12 || lat !== 13) begin
            n_fail++;
            $display("FAIL busy_disturb_timing: busy=%0d latency=%0d expected 12 and 13", bn, lat);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_disturb_restart: busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] p, k, e;
        int lat, bn, fn, cc, cb, dn;
        logic da;
        p = 128'h0BADC0DE_8BADF00D_FEEDFACE_C0FFEE00;
        k = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        set_key(k);
        load_state(p);
        start = 1'b1;
        num_steps = 6'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: busy=%b expected 1", busy); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fresh_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: busy=%b done=%b fresh_en=%b expected 000", busy, done, fresh_en);
        end
        n_checks++;
        if ((st_out[0] | st_out[1] | st_out[2] | st_out[3]) !== 128'h0 || (cx[0] | cx[1] | cx[2] | cx[3]) !== 47'h0) begin
            n_fail++;
            $display("FAIL mid_reset_data: state=%h core_x=%h expected 0",
                     st_out[0] | st_out[1] | st_out[2] | st_out[3], cx[0] | cx[1] | cx[2] | cx[3]);
        end
        @(negedge clk);
        rst = 1'b1;
        bn = 0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) bn++;
            if (done) dn++;
            @(negedge clk);
        end
        n_checks++;
        if (bn !== 0 || dn !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: busy=%0d done=%0d expected 0 0", bn, dn);
        end
        p = 128'h31415926_53589793_23846264_33832795;
        e = ref_perm(p, k, 12);
        load_state(p);
        run_perm(12, 1'b0, lat, bn, fn, cc, cb, da);
        n_checks++;
        if (rec() !== e || lat !== 37) begin
            n_fail++;
            $display("FAIL mid_reset_rerun: state=%h latency=%0d expected %h and 37", rec(), lat, e);
        end
    endtask

    task automatic test_idle_core_x();
        logic [46:0] exp_x [4];
        load_state(128'h27182818_28459045_23536028_74713526);
        for (int i = 0; i < 4; i++) begin
`ifdef NLFSR_CTRL_IDLE_ZERO_EN
            exp_x[i] = '0;
`else
            exp_x[i] = st_in[i][116:70];
`endif
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cx[i] !== exp_x[i]) begin
                n_fail++;
                $display("FAIL idle_core_x%0d: got %h expected %h", i, cx[i], exp_x[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        load = 1'b0;
        start = 1'b0;
        num_steps = '0;
        for (int i = 0; i < 4; i++) begin
            st_in[i] = '0;
            key[i]   = '0;
        end
        #3;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_zero_state();
        test_random_runs();
        test_reshare();
        test_zero_steps();
        test_load_start();
        test_reset_mid();
        test_idle_core_x();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
